// File: rtl/rom_port_arbiter_if.sv
// Bundle of the fetch, load and ROM-side signals around the shared ROM read port.
// The slave modport is the arbiter; master is the requesters plus the ROM.
interface rom_port_arbiter_if #(
    parameter int ADDR_WIDTH = 32
);
    logic                  if_req;
    logic [ADDR_WIDTH-1:0] if_addr;
    logic                  if_gnt;
    logic                  if_rvalid;
    logic [31:0]           if_rdata;

    logic                  ls_req;
    logic [ADDR_WIDTH-1:0] ls_addr;
    logic [1:0]            ls_size;
    logic                  ls_unsigned;
    logic                  ls_gnt;
    logic                  ls_rvalid;
    logic [31:0]           ls_rdata;
    logic                  ls_err;

    logic [ADDR_WIDTH-1:0] rom_addr;
    logic [31:0]           rom_data;

    modport master (
        output if_req, if_addr, ls_req, ls_addr, ls_size, ls_unsigned, rom_data,
        input  if_gnt, if_rvalid, if_rdata, ls_gnt, ls_rvalid, ls_rdata, ls_err, rom_addr
    );

    modport slave (
        input  if_req, if_addr, ls_req, ls_addr, ls_size, ls_unsigned, rom_data,
        output if_gnt, if_rvalid, if_rdata, ls_gnt, ls_rvalid, ls_rdata, ls_err, rom_addr
    );
endinterface

// File: rtl/rom_port_arbiter.sv
// Round-robin sharing of the combinational program-ROM read port between
// instruction fetch and the load unit, with load byte/half extraction.
module rom_port_arbiter #(
    parameter int ADDR_WIDTH  = 32,
    parameter bit FETCH_FIRST = 1'b1
) (
    input logic            clk,
    input logic            rst,
    rom_port_arbiter_if.slave bus
);
    logic                  last_ls;
    logic                  grant_if;
    logic                  grant_ls;
    logic [ADDR_WIDTH-1:0] gnt_addr;
    logic [ADDR_WIDTH-1:0] rom_addr_q;
    logic                  ls_bad;
    logic [7:0]            ls_byte;
    logic [15:0]           ls_half;
    logic [31:0]           ls_ext;

    logic                  if_rvalid_q;
    logic [31:0]           if_rdata_q;
    logic                  ls_rvalid_q;
    logic [31:0]           ls_rdata_q;
    logic                  ls_err_q;

    // Tie goes to whichever port did not win last; reset gates both grants.
    always_comb begin
        grant_if = !rst && bus.if_req && (!bus.ls_req || last_ls);
        grant_ls = !rst && bus.ls_req && (!bus.if_req || !last_ls);
        gnt_addr = grant_ls ? bus.ls_addr : bus.if_addr;
    end

    always_comb begin
        ls_byte = 8'(bus.rom_data >> {bus.ls_addr[1:0], 3'b000});
        ls_half = bus.ls_addr[1] ? bus.rom_data[31:16] : bus.rom_data[15:0];
        ls_bad  = (bus.ls_size == 2'b11)
               || (bus.ls_size == 2'b01 && bus.ls_addr[0])
               || (bus.ls_size == 2'b10 && bus.ls_addr[1:0] != 2'b00);
        ls_ext  = '0;
        case (bus.ls_size)
            2'b00:   ls_ext = {{24{!bus.ls_unsigned && ls_byte[7]}}, ls_byte};
            2'b01:   ls_ext = {{16{!bus.ls_unsigned && ls_half[15]}}, ls_half};
            2'b10:   ls_ext = bus.rom_data;
            default: ls_ext = '0;
        endcase
        if (ls_bad) begin
            ls_ext = '0;
        end
    end

    // Address only moves on a grant so the ROM never sees a spurious access.
    assign bus.rom_addr = rst ? '0
                        : (grant_if || grant_ls) ? (gnt_addr & ~ADDR_WIDTH'(3))
                        : rom_addr_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            last_ls     <= FETCH_FIRST;
            rom_addr_q  <= '0;
            if_rvalid_q <= 1'b0;
            if_rdata_q  <= '0;
            ls_rvalid_q <= 1'b0;
            ls_rdata_q  <= '0;
            ls_err_q    <= 1'b0;
        end else begin
            if (grant_if || grant_ls) begin
                last_ls    <= grant_ls;
                rom_addr_q <= bus.rom_addr;
            end
            if_rvalid_q <= grant_if;
            if (grant_if) begin
                if_rdata_q <= bus.rom_data;
            end
            ls_rvalid_q <= grant_ls;
            ls_err_q    <= grant_ls && ls_bad;
            if (grant_ls) begin
                ls_rdata_q <= ls_ext;
            end
        end
    end

    assign bus.if_gnt    = grant_if;
    assign bus.ls_gnt    = grant_ls;
    assign bus.if_rvalid = if_rvalid_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.ls_rvalid = ls_rvalid_q;
    assign bus.ls_rdata  = ls_rdata_q;
    assign bus.ls_err    = ls_err_q;
endmodule

// File: tb/tb_rom_port_arbiter.sv
// Bench for rom_port_arbiter: directed scenarios plus a randomized run checked
// against a byte-addressed ROM model and round-robin grant rules.
module tb_rom_port_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    rom_port_arbiter_if #(.ADDR_WIDTH(32)) bus ();

    rom_port_arbiter #(.ADDR_WIDTH(32), .FETCH_FIRST(1'b1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    function automatic logic [7:0] rb(input logic [31:0] a);
        logic [31:0] t;
        case (a)
            32'h100: return 8'h80;
            32'h101: return 8'h7F;
            32'h102: return 8'h01;
            32'h103: return 8'hFF;
            default: begin
                t = a * 32'd29 + 32'd91;
                return t[7:0] ^ a[9:2];
            end
        endcase
    endfunction

    always_comb bus.rom_data = {rb(bus.rom_addr + 32'd3), rb(bus.rom_addr + 32'd2),
                                rb(bus.rom_addr + 32'd1), rb(bus.rom_addr)};

    function automatic logic [31:0] word_at(input logic [31:0] a);
        logic [31:0] w;
        w = {a[31:2], 2'b00};
        return {rb(w + 32'd3), rb(w + 32'd2), rb(w + 32'd1), rb(w)};
    endfunction

    // Load result from byte-addressed memory view.
    function automatic void load_ref(input logic [31:0] a, input logic [1:0] sz, input logic uns,
                                     output logic err, output logic [31:0] d);
        logic [7:0]  b;
        logic [15:0] h;
        err = (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0);
        d = 32'd0;
        if (!err) begin
            if (sz == 2'd0) begin
                b = rb(a);
                d = uns ? {24'd0, b} : {{24{b[7]}}, b};
            end else if (sz == 2'd1) begin
                h = {rb(a + 32'd1), rb(a)};
                d = uns ? {16'd0, h} : {{16{h[15]}}, h};
            end else begin
                d = {rb(a + 32'd3), rb(a + 32'd2), rb(a + 32'd1), rb(a)};
            end
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.if_req      = 1'b0;
        bus.ls_req      = 1'b0;
        bus.if_addr     = 32'h0;
        bus.ls_addr     = 32'h0;
        bus.ls_size     = 2'd0;
        bus.ls_unsigned = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.if_req = 1'b1; bus.if_addr = 32'h100;
        bus.ls_req = 1'b1; bus.ls_addr = 32'h100; bus.ls_size = 2'd2;
        tick(); tick(); #3;
        n_cmp++; if (bus.if_gnt !== 1'b0) begin n_bad++; $display("FAIL reset_if_gnt got %0h want 0", bus.if_gnt); end
        n_cmp++; if (bus.ls_gnt !== 1'b0) begin n_bad++; $display("FAIL reset_ls_gnt got %0h want 0", bus.ls_gnt); end
        n_cmp++; if (bus.if_rvalid !== 1'b0) begin n_bad++; $display("FAIL reset_if_rvalid got %0h want 0", bus.if_rvalid); end
        n_cmp++; if (bus.ls_rvalid !== 1'b0) begin n_bad++; $display("FAIL reset_ls_rvalid got %0h want 0", bus.ls_rvalid); end
        n_cmp++; if (bus.ls_err !== 1'b0) begin n_bad++; $display("FAIL reset_ls_err got %0h want 0", bus.ls_err); end
        n_cmp++; if (bus.if_rdata !== 32'h0) begin n_bad++; $display("FAIL reset_if_rdata got %0h want 0", bus.if_rdata); end
        n_cmp++; if (bus.ls_rdata !== 32'h0) begin n_bad++; $display("FAIL reset_ls_rdata got %0h want 0", bus.ls_rdata); end
        n_cmp++; if (bus.rom_addr !== 32'h0) begin n_bad++; $display("FAIL reset_rom_addr got %0h want 0", bus.rom_addr); end
        idle();
        tick();
    endtask

    task automatic test_fetch();
        rst = 1'b0;
        bus.if_req = 1'b1; bus.if_addr = 32'h102;
        #3;
        n_cmp++; if (bus.if_gnt !== 1'b1) begin n_bad++; $display("FAIL fetch_gnt got %0h want 1", bus.if_gnt); end
        n_cmp++; if (bus.ls_gnt !== 1'b0) begin n_bad++; $display("FAIL fetch_ls_gnt got %0h want 0", bus.ls_gnt); end
        n_cmp++; if (bus.rom_addr !== 32'h100) begin n_bad++; $display("FAIL fetch_rom_addr got %0h want 100", bus.rom_addr); end
        tick();
        bus.if_req = 1'b0;
        #3;
        n_cmp++; if (bus.if_rvalid !== 1'b1) begin n_bad++; $display("FAIL fetch_rvalid got %0h want 1", bus.if_rvalid); end
        n_cmp++; if (bus.if_rdata !== 32'hFF017F80) begin n_bad++; $display("FAIL fetch_rdata got %0h want ff017f80", bus.if_rdata); end
        n_cmp++; if (bus.rom_addr !== 32'h100) begin n_bad++; $display("FAIL fetch_rom_hold got %0h want 100", bus.rom_addr); end
        tick(); #3;
        n_cmp++; if (bus.if_rvalid !== 1'b0) begin n_bad++; $display("FAIL fetch_rvalid_pulse got %0h want 0", bus.if_rvalid); end
        n_cmp++; if (bus.if_rdata !== 32'hFF017F80) begin n_bad++; $display("FAIL fetch_rdata_hold got %0h want ff017f80", bus.if_rdata); end
        tick();
    endtask

    task automatic test_loads();
        logic [31:0] addr_t [4];
        logic [1:0]  size_t [4];
        logic        uns_t  [4];
        logic [31:0] exp_t  [4];
        addr_t[0] = 32'h100; size_t[0] = 2'd0; uns_t[0] = 1'b0; exp_t[0] = 32'hFFFFFF80;
        addr_t[1] = 32'h100; size_t[1] = 2'd0; uns_t[1] = 1'b1; exp_t[1] = 32'h00000080;
        addr_t[2] = 32'h102; size_t[2] = 2'd1; uns_t[2] = 1'b0; exp_t[2] = 32'hFFFFFF01;
        addr_t[3] = 32'h100; size_t[3] = 2'd1; uns_t[3] = 1'b1; exp_t[3] = 32'h00007F80;
        for (int i = 0; i < 4; i++) begin
            bus.ls_req = 1'b1; bus.ls_addr = addr_t[i]; bus.ls_size = size_t[i]; bus.ls_unsigned = uns_t[i];
            #3;
            n_cmp++; if (bus.ls_gnt !== 1'b1) begin n_bad++; $display("FAIL load%0d_gnt got %0h want 1", i, bus.ls_gnt); end
            tick();
            bus.ls_req = 1'b0;
            #3;
            n_cmp++; if (bus.ls_rvalid !== 1'b1) begin n_bad++; $display("FAIL load%0d_rvalid got %0h want 1", i, bus.ls_rvalid); end
            n_cmp++; if (bus.ls_rdata !== exp_t[i]) begin n_bad++; $display("FAIL load%0d_rdata got %0h want %0h", i, bus.ls_rdata, exp_t[i]); end
            n_cmp++; if (bus.ls_err !== 1'b0) begin n_bad++; $display("FAIL load%0d_err got %0h want 0", i, bus.ls_err); end
            tick();
        end
    endtask

    task automatic test_contention();
        rst = 1'b1; idle();
        tick();
        rst = 1'b0;
        bus.if_req = 1'b1; bus.if_addr = 32'h100;
        bus.ls_req = 1'b1; bus.ls_addr = 32'h100; bus.ls_size = 2'd2; bus.ls_unsigned = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #3;
            n_cmp++; if (bus.if_gnt !== (i % 2 == 0)) begin n_bad++; $display("FAIL cont%0d_if_gnt got %0h want %0h", i, bus.if_gnt, (i % 2 == 0)); end
            n_cmp++; if (bus.ls_gnt !== (i % 2 == 1)) begin n_bad++; $display("FAIL cont%0d_ls_gnt got %0h want %0h", i, bus.ls_gnt, (i % 2 == 1)); end
            if (i > 0) begin
                n_cmp++; if (bus.if_rvalid !== (i % 2 == 1)) begin n_bad++; $display("FAIL cont%0d_if_rvalid got %0h want %0h", i, bus.if_rvalid, (i % 2 == 1)); end
                n_cmp++; if (bus.ls_rvalid !== (i % 2 == 0)) begin n_bad++; $display("FAIL cont%0d_ls_rvalid got %0h want %0h", i, bus.ls_rvalid, (i % 2 == 0)); end
            end
            tick();
        end
        idle();
        #3;
        n_cmp++; if (bus.ls_rvalid !== 1'b1) begin n_bad++; $display("FAIL cont_last_ls_rvalid got %0h want 1", bus.ls_rvalid); end
        n_cmp++; if (bus.ls_rdata !== 32'hFF017F80) begin n_bad++; $display("FAIL cont_ls_rdata got %0h want ff017f80", bus.ls_rdata); end
        n_cmp++; if (bus.if_rdata !== 32'hFF017F80) begin n_bad++; $display("FAIL cont_if_rdata got %0h want ff017f80", bus.if_rdata); end
        tick();
    endtask

    task automatic test_misaligned();
        logic [31:0] addr_t [2];
        logic [1:0]  size_t [2];
        addr_t[0] = 32'h101; size_t[0] = 2'd2;
        addr_t[1] = 32'h100; size_t[1] = 2'd3;
        for (int i = 0; i < 2; i++) begin
            bus.ls_req = 1'b1; bus.ls_addr = addr_t[i]; bus.ls_size = size_t[i]; bus.ls_unsigned = 1'b0;
            #3;
            n_cmp++; if (bus.ls_gnt !== 1'b1) begin n_bad++; $display("FAIL mis%0d_gnt got %0h want 1", i, bus.ls_gnt); end
            tick();
            bus.ls_req = 1'b0;
            #3;
            n_cmp++; if (bus.ls_rvalid !== 1'b1) begin n_bad++; $display("FAIL mis%0d_rvalid got %0h want 1", i, bus.ls_rvalid); end
            n_cmp++; if (bus.ls_err !== 1'b1) begin n_bad++; $display("FAIL mis%0d_err got %0h want 1", i, bus.ls_err); end
            n_cmp++; if (bus.ls_rdata !== 32'h0) begin n_bad++; $display("FAIL mis%0d_rdata got %0h want 0", i, bus.ls_rdata); end
            tick();
        end
    endtask

    task automatic test_reset_midop();
        bus.ls_req = 1'b1; bus.ls_addr = 32'h100; bus.ls_size = 2'd2; bus.ls_unsigned = 1'b0;
        #3;
        n_cmp++; if (bus.ls_gnt !== 1'b1) begin n_bad++; $display("FAIL midop_ls_gnt got %0h want 1", bus.ls_gnt); end
        tick();
        rst = 1'b1;
        bus.ls_req = 1'b0;
        bus.if_req = 1'b1; bus.if_addr = 32'h104;
        #3;
        n_cmp++; if (bus.if_gnt !== 1'b0) begin n_bad++; $display("FAIL midop_if_gnt got %0h want 0", bus.if_gnt); end
        n_cmp++; if (bus.rom_addr !== 32'h0) begin n_bad++; $display("FAIL midop_rom_addr got %0h want 0", bus.rom_addr); end
        tick();
        bus.if_req = 1'b0;
        #3;
        n_cmp++; if (bus.if_rvalid !== 1'b0) begin n_bad++; $display("FAIL midop_if_rvalid got %0h want 0", bus.if_rvalid); end
        n_cmp++; if (bus.ls_rvalid !== 1'b0) begin n_bad++; $display("FAIL midop_ls_rvalid got %0h want 0", bus.ls_rvalid); end
        n_cmp++; if (bus.ls_rdata !== 32'h0) begin n_bad++; $display("FAIL midop_ls_rdata got %0h want 0", bus.ls_rdata); end
        n_cmp++; if (bus.if_rdata !== 32'h0) begin n_bad++; $display("FAIL midop_if_rdata got %0h want 0", bus.if_rdata); end
        tick();
        rst = 1'b0;
        bus.if_req = 1'b1; bus.if_addr = 32'h100;
        bus.ls_req = 1'b1; bus.ls_addr = 32'h104; bus.ls_size = 2'd2;
        #3;
        n_cmp++; if (bus.if_gnt !== 1'b1) begin n_bad++; $display("FAIL midop_prio_if got %0h want 1", bus.if_gnt); end
        n_cmp++; if (bus.ls_gnt !== 1'b0) begin n_bad++; $display("FAIL midop_prio_ls got %0h want 0", bus.ls_gnt); end
        tick();
        idle();
        #3;
        n_cmp++; if (bus.if_rvalid !== 1'b1) begin n_bad++; $display("FAIL midop_fetch_rvalid got %0h want 1", bus.if_rvalid); end
        n_cmp++; if (bus.if_rdata !== 32'hFF017F80) begin n_bad++; $display("FAIL midop_fetch_rdata got %0h want ff017f80", bus.if_rdata); end
        tick();
    endtask

    task automatic test_random();
        logic        prefer_if;
        logic        e_if_gnt, e_ls_gnt;
        logic        e_if_rv, e_ls_rv, e_ls_err, l_err;
        logic [31:0] e_if_rd, e_ls_rd, e_rom, l_data;
        rst = 1'b1; idle();
        tick();
        rst = 1'b0;
        prefer_if = 1'b1;
        e_if_gnt = 1'b0; e_ls_gnt = 1'b0;
        e_if_rv = 1'b0; e_ls_rv = 1'b0; e_ls_err = 1'b0;
        e_if_rd = 32'h0; e_ls_rd = 32'h0; e_rom = 32'h0;
        for (int c = 0; c < 400; c++) begin
            // Ungranted requests normally persist; occasionally one is withdrawn.
            if (!(bus.if_req && !e_if_gnt && $urandom_range(0, 9) != 0)) begin
                bus.if_req  = ($urandom_range(0, 2) != 0);
                bus.if_addr = $urandom_range(32'h0F8, 32'h10F);
            end
            if (!(bus.ls_req && !e_ls_gnt && $urandom_range(0, 9) != 0)) begin
                bus.ls_req      = ($urandom_range(0, 2) != 0);
                bus.ls_addr     = $urandom_range(32'h0F8, 32'h10F);
                bus.ls_size     = 2'($urandom_range(0, 3));
                bus.ls_unsigned = 1'($urandom_range(0, 1));
            end
            e_if_gnt = bus.if_req && (!bus.ls_req || prefer_if);
            e_ls_gnt = bus.ls_req && (!bus.if_req || !prefer_if);
            if (e_if_gnt) e_rom = {bus.if_addr[31:2], 2'b00};
            if (e_ls_gnt) e_rom = {bus.ls_addr[31:2], 2'b00};
            #3;
            n_cmp++; if (bus.if_gnt !== e_if_gnt) begin n_bad++; $display("FAIL rnd%0d_if_gnt got %0h want %0h", c, bus.if_gnt, e_if_gnt); end
            n_cmp++; if (bus.ls_gnt !== e_ls_gnt) begin n_bad++; $display("FAIL rnd%0d_ls_gnt got %0h want %0h", c, bus.ls_gnt, e_ls_gnt); end
            n_cmp++; if (bus.rom_addr !== e_rom) begin n_bad++; $display("FAIL rnd%0d_rom_addr got %0h want %0h", c, bus.rom_addr, e_rom); end
            n_cmp++; if (bus.if_rvalid !== e_if_rv) begin n_bad++; $display("FAIL rnd%0d_if_rvalid got %0h want %0h", c, bus.if_rvalid, e_if_rv); end
            n_cmp++; if (bus.if_rdata !== e_if_rd) begin n_bad++; $display("FAIL rnd%0d_if_rdata got %0h want %0h", c, bus.if_rdata, e_if_rd); end
            n_cmp++; if (bus.ls_rvalid !== e_ls_rv) begin n_bad++; $display("FAIL rnd%0d_ls_rvalid got %0h want %0h", c, bus.ls_rvalid, e_ls_rv); end
            n_cmp++; if (bus.ls_rdata !== e_ls_rd) begin n_bad++; $display("FAIL rnd%0d_ls_rdata got %0h want %0h", c, bus.ls_rdata, e_ls_rd); end
            if (e_ls_rv) begin
                n_cmp++; if (bus.ls_err !== e_ls_err) begin n_bad++; $display("FAIL rnd%0d_ls_err got %0h want %0h", c, bus.ls_err, e_ls_err); end
            end
            e_if_rv = e_if_gnt;
            e_ls_rv = e_ls_gnt;
            if (e_if_gnt) begin
                e_if_rd   = word_at(bus.if_addr);
                prefer_if = 1'b0;
            end
            if (e_ls_gnt) begin
                load_ref(bus.ls_addr, bus.ls_size, bus.ls_unsigned, l_err, l_data);
                e_ls_rd   = l_data;
                e_ls_err  = l_err;
                prefer_if = 1'b1;
            end
            tick();
        end
        idle();
    endtask

    initial begin
        idle();
        test_reset();
        test_fetch();
        test_loads();
        test_contention();
        test_misaligned();
        test_reset_midop();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/rom_port_arbiter.md
Name: rom_port_arbiter

Overview:
- Shares the single combinational read port of the byte-addressed program ROM between the instruction-fetch stage (IF) and the load unit (LS), so read-only data can be loaded from ROM.
- Arbitrates each cycle with round-robin priority.
- Issues a word-aligned address to the ROM and registers the returned word.
- For LS, extracts the requested byte or halfword and sign- or zero-extends it.

Parameters:
- ADDR_WIDTH, 32, width of requester and ROM addresses.
- FETCH_FIRST, 1, requester that wins the first tie after reset: 1 = IF, 0 = LS.

Ports:
- clk  input  1  system clock, all state updates on the rising edge
- rst  input  1  synchronous, active-high reset
- if_req  input  1  fetch request
- if_addr  input  ADDR_WIDTH  fetch byte address; bits [1:0] are ignored
- if_gnt  output  1  fetch request accepted this cycle
- if_rvalid  output  1  if_rdata valid; one-cycle pulse
- if_rdata  output  32  fetched instruction word
- ls_req  input  1  load request
- ls_addr  input  ADDR_WIDTH  load byte address
- ls_size  input  2  00 = byte, 01 = half, 10 = word, 11 = reserved
- ls_unsigned  input  1  1 = zero-extend, 0 = sign-extend
- ls_gnt  output  1  load request accepted this cycle
- ls_rvalid  output  1  ls_rdata or ls_err valid; one-cycle pulse
- ls_rdata  output  32  extended load result
- ls_err  output  1  misaligned or reserved-size load; qualified by ls_rvalid
- rom_addr  output  ADDR_WIDTH  word-aligned address to ROM
- rom_data  input  32  little-endian ROM word, combinational from rom_addr

Behaviour:
- Reset values, held while rst = 1 (gnt outputs gated combinationally by rst):
  - if_gnt, ls_gnt, if_rvalid, ls_rvalid, ls_err = 0
  - if_rdata, ls_rdata = 0
  - rom_addr = 0
  - last_winner = LS if FETCH_FIRST = 1, else IF
- Arbitration is combinational within the cycle:
  - Only one requester active: it is granted.
  - Both active: the one that is not last_winner is granted.
  - last_winner updates at the edge whenever a grant occurs.
  - if_gnt and ls_gnt are never both 1.
- rom_addr = {granted_addr[ADDR_WIDTH-1:2], 2'b00}.
  - With no grant, rom_addr holds its previous registered value; no glitch-driven accesses.
- Latency is exactly 1 cycle:
  - A request granted in cycle N samples rom_data at the end of cycle N.
  - The matching rvalid is high in cycle N+1 with registered rdata.
  - rdata holds its value until the next rvalid for that port.
- Throughput is one access per cycle in total. Back-to-back grants to the same port are allowed when the other port is idle.
- Handshake:
  - A requester holds req, addr, size and unsigned stable until it sees gnt.
  - It may present a new request in the cycle after gnt.
  - A request deasserted before grant is dropped silently.
- LS extraction, with b = ls_addr[1:0]:
  - Byte: lane b, i.e. rom_data[8b+7:8b].
  - Half: lane ls_addr[1], i.e. rom_data[16*ls_addr[1]+15 : 16*ls_addr[1]].
  - Word: full rom_data.
  - Byte and half results are extended to 32 bits according to ls_unsigned.
- LS errors: half with b[0] = 1, word with b != 00, or size = 11.
  - The request is still granted and consumes the slot (round-robin updates).
  - Next cycle: ls_rvalid = 1, ls_err = 1, ls_rdata = 0.
- IF: if_addr[1:0] are ignored and no IF error is raised.
- Reset mid-operation: a grant in the cycle rst rises produces no rvalid. Pending results are discarded and outputs return to reset values on the next edge.
- No internal queue: each port has at most one outstanding response.

Test Plan:
- ROM holds bytes 0x80, 0x7F, 0x01, 0xFF at 0x100..0x103.
- Single fetch: if_req = 1, if_addr = 0x102 -> if_gnt same cycle, rom_addr = 0x100; next cycle if_rvalid = 1, if_rdata = 0xFF017F80.
- Byte loads at 0x100: signed -> ls_rdata = 0xFFFFFF80; ls_unsigned = 1 -> 0x00000080.
- Half loads: addr 0x102 signed -> 0xFFFFFF01; addr 0x100 unsigned -> 0x00007F80.
- Contention: if_req and ls_req both held high for 4 cycles after reset (FETCH_FIRST = 1) -> grants IF, LS, IF, LS; never both in one cycle; rvalids follow one cycle later.
- Misaligned: word load at 0x101 -> ls_gnt = 1; next cycle ls_rvalid = 1, ls_err = 1, ls_rdata = 0. Repeat with size = 11: same response.
- Reset mid-op: assert rst in the grant cycle of a fetch -> if_rvalid stays 0. After rst drops, a fresh fetch returns correct data and arbitration restarts with IF priority.
